fifo_operand_dispatcher: RTL and testbench
==========================================

// Module: fifo_operand_dispatcher
// PURPOSE
//  Read-side consumer of the MAC operand FIFO. Watches the FIFO head (two entries visible), pops
//  operand pairs via Pop2 (or a single padded operand via Pop1 on flush), holds them in an output
//  register and presents (OpA, OpB) to the MAC datapath with a valid/ready handshake.
//  Sustains one pair per cycle when the FIFO holds >=2 entries and the MAC accepts every cycle.
// PARAMETERS
//  DataWidth   32  operand width, equal to FIFO DataWidth
//  BufferSize  4   FIFO depth, width of ReadyM
//  CountWidth  16  width of dispatched-pair counter
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-low reset
//  Empty      in   1            FIFO empty flag
//  ReadyM     in   BufferSize   FIFO entry-valid mask; bit i=1 -> head+i entry valid
//  FifoData1  in   DataWidth    FIFO DataOut1 (head entry)
//  FifoData2  in   DataWidth    FIFO DataOut2 (head+1 entry)
//  Pop1       out  1            pop one entry (to FIFO)
//  Pop2       out  1            pop two entries (to FIFO)
//  Flush      in   1            level: allow odd trailing entry to be sent padded
//  OpA        out  DataWidth    operand A (from head entry)
//  OpB        out  DataWidth    operand B (head+1 entry, or 0 when padded)
//  OpPad      out  1            OpB is zero padding
//  OpValid    out  1            operand pair valid
//  OpReady    in   1            MAC accepts pair
//  PairCount  out  CountWidth   pairs handed off since reset
//  Busy       out  1            OpValid | Flush pending with ReadyM[0]
// BEHAVIOUR
//  - Reset (rst=0, async): OpA=OpB=0, OpPad=0, OpValid=0, PairCount=0; Pop1/Pop2 then evaluate 0.
//  - States: IDLE (OpValid=0) and HOLD (OpValid=1). State change only on rising clk.
//  - avail2 = !Empty & ReadyM[1]; avail1 = !Empty & ReadyM[0] & !ReadyM[1].
//  - slot = !OpValid | OpReady (output register free now or freed this cycle).
//  - Pop2 = slot & avail2; Pop1 = slot & avail1 & Flush. Combinational; never both high.
//  - On Pop2 edge: OpA<=FifoData1, OpB<=FifoData2, OpPad<=0, OpValid<=1 (stay/enter HOLD).
//  - On Pop1 edge: OpA<=FifoData1, OpB<=0, OpPad<=1, OpValid<=1.
//  - Handshake OpValid&OpReady with no pop: OpValid<=0 (HOLD->IDLE); OpA/OpB keep last value.
//  - Handshake plus pop same cycle: back-to-back reload, OpValid stays 1 (zero bubble).
//  - HOLD with OpReady=0: OpA/OpB/OpPad stable, no pops regardless of FIFO state.
//  - Single entry without Flush: wait in IDLE, no pop. Empty=1 overrides ReadyM (no pop).
//  - PairCount += 1 per handshake (padded included); wraps 2^CountWidth-1 -> 0, no flag.
//  - Latency: FIFO pair available -> OpValid high on next rising edge (1 cycle).
//  - Reset mid-operation: held pair discarded; FIFO contents untouched (FIFO reset separately).
// STRUCTURE
//  - mac_pkg: DataWidth default, state encoding localparams IDLE/HOLD.
//  - One sub-module: operand_hold_reg (load/clear-valid output register for OpA/OpB/OpPad/OpValid).
//  - Top holds pop logic and PairCount.
// TESTING
//  - Reset: rst=0 with ReadyM=4'b1111 -> Pop1=Pop2=0, OpValid=0, PairCount=0 until rst=1.
//  - Push 1,2,3,4 into FIFO, OpReady=1 -> Pop2 two consecutive cycles; pairs (1,2),(3,4), PairCount=2.
//  - Same fill, OpReady=0 for 3 cycles -> (1,2) held stable, Pop2=0 throughout; on OpReady=1 (3,4) next cycle.
//  - Push 5,6,7, Flush=0 -> (5,6) sent, 7 waits; assert Flush -> Pop1, OpA=7, OpB=0, OpPad=1.
//  - Empty=1 with stale ReadyM=4'b0011 -> no pops, OpValid stays 0.
//  - Force PairCount to 16'hFFFF (CountWidth=16) then one handshake -> PairCount=0;
//    async rst low mid-HOLD -> OpValid drops immediately, no clk edge needed.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC operand path.
// Holds the operand width default and the dispatcher state encoding.
package mac_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/operand_hold_reg.sv
// Output register for one operand pair.
// A load always wins over a valid clear, giving zero-bubble reloads.
module operand_hold_reg
  import mac_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 pad,
  input  logic                 clr,
  input  logic [DataWidth-1:0] din_a,
  input  logic [DataWidth-1:0] din_b,
  output logic [DataWidth-1:0] op_a,
  output logic [DataWidth-1:0] op_b,
  output logic                 op_pad,
  output logic                 op_valid
);

  state_e               state_q, state_d;
  logic [DataWidth-1:0] a_q, a_d;
  logic [DataWidth-1:0] b_q, b_d;
  logic                 pad_q, pad_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pad_d   = pad_q;
    if (load) begin
      state_d = HOLD;
      a_d     = din_a;
      b_d     = pad ? '0 : din_b;
      pad_d   = pad;
    end else if (clr) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pad_q   <= pad_d;
    end
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_pad   = pad_q;
  assign op_valid = (state_q == HOLD);

endmodule

// File: rtl/fifo_operand_dispatcher.sv
// Read-side consumer of the MAC operand FIFO.
// Pops pairs (or a padded single on flush) into a valid/ready output stage.
module fifo_operand_dispatcher
  import mac_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH,
  parameter int BufferSize = 4,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Empty,
  input  logic [BufferSize-1:0] ReadyM,
  input  logic [DataWidth-1:0]  FifoData1,
  input  logic [DataWidth-1:0]  FifoData2,
  output logic                  Pop1,
  output logic                  Pop2,
  input  logic                  Flush,
  output logic [DataWidth-1:0]  OpA,
  output logic [DataWidth-1:0]  OpB,
  output logic                  OpPad,
  output logic                  OpValid,
  input  logic                  OpReady,
  output logic [CountWidth-1:0] PairCount,
  output logic                  Busy
);

  logic                  avail2, avail1;
  logic                  slot, hshake;
  logic                  unused_ready_hi;
  logic [CountWidth-1:0] cnt_q, cnt_d;

  assign avail2 = !Empty & ReadyM[1];
  assign avail1 = !Empty & ReadyM[0] & !ReadyM[1];
  assign slot   = !OpValid | OpReady;
  assign hshake = OpValid & OpReady;

  // Gated by rst so the FIFO is never popped while held in reset.
  assign Pop2 = rst & slot & avail2;
  assign Pop1 = rst & slot & avail1 & Flush;

  assign unused_ready_hi = ^ReadyM[BufferSize-1:2];

  operand_hold_reg #(
    .DataWidth(DataWidth)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (Pop1 | Pop2),
    .pad     (Pop1),
    .clr     (hshake),
    .din_a   (FifoData1),
    .din_b   (FifoData2),
    .op_a    (OpA),
    .op_b    (OpB),
    .op_pad  (OpPad),
    .op_valid(OpValid)
  );

  always_comb begin
    cnt_d = cnt_q + CountWidth'(hshake);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign PairCount = cnt_q;
  assign Busy      = OpValid | (Flush & ReadyM[0]);

endmodule

// File: tb/tb_fifo_operand_dispatcher.sv
// Bench for fifo_operand_dispatcher: queue-based FIFO and pair model.
// A second narrow-counter instance exercises PairCount wraparound.
module tb_fifo_operand_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        Empty, Flush, OpReady;
  logic [3:0]  ReadyM;
  logic [31:0] FifoData1, FifoData2;
  logic        Pop1, Pop2, OpPad, OpValid, Busy;
  logic [31:0] OpA, OpB;
  logic [15:0] PairCount;
  logic        w_pop1, w_pop2, w_pad, w_valid, w_busy;
  logic [31:0] w_a, w_b;
  logic [3:0]  w_cnt;

  always #5 clk = ~clk;

  fifo_operand_dispatcher #(
    .DataWidth(32), .BufferSize(4), .CountWidth(16)
  ) dut (
    .clk(clk), .rst(rst), .Empty(Empty), .ReadyM(ReadyM),
    .FifoData1(FifoData1), .FifoData2(FifoData2),
    .Pop1(Pop1), .Pop2(Pop2), .Flush(Flush),
    .OpA(OpA), .OpB(OpB), .OpPad(OpPad), .OpValid(OpValid),
    .OpReady(OpReady), .PairCount(PairCount), .Busy(Busy)
  );

  fifo_operand_dispatcher #(
    .DataWidth(32), .BufferSize(4), .CountWidth(4)
  ) dut4 (
    .clk(clk), .rst(rst), .Empty(Empty), .ReadyM(ReadyM),
    .FifoData1(FifoData1), .FifoData2(FifoData2),
    .Pop1(w_pop1), .Pop2(w_pop2), .Flush(Flush),
    .OpA(w_a), .OpB(w_b), .OpPad(w_pad), .OpValid(w_valid),
    .OpReady(OpReady), .PairCount(w_cnt), .Busy(w_busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  bit          stale;

  bit          mv, mpad;
  logic [31:0] ma, mb;
  int unsigned mcnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    int n;
    n = q.size();
    Empty     = stale ? 1'b1 : (n == 0);
    ReadyM    = stale ? 4'b0011 : 4'((1 << n) - 1);
    FifoData1 = (n > 0) ? q[0] : 32'hDEAD_0001;
    FifoData2 = (n > 1) ? q[1] : 32'hDEAD_0002;
  endtask

  task automatic check_all(output bit e1, output bit e2);
    int n;
    bit slot, av1, av2, rm0;
    n    = q.size();
    av2  = !stale && n >= 2;
    av1  = !stale && n == 1;
    rm0  = stale || n >= 1;
    slot = !mv || OpReady;
    e2   = rst && slot && av2;
    e1   = rst && slot && av1 && Flush;
    chk("pop1", 32'(Pop1), 32'(e1));
    chk("pop2", 32'(Pop2), 32'(e2));
    chk("opvalid", 32'(OpValid), 32'(mv));
    chk("opa", OpA, ma);
    chk("opb", OpB, mb);
    chk("oppad", 32'(OpPad), 32'(mpad));
    chk("paircount", 32'(PairCount), mcnt & 32'hFFFF);
    chk("paircount4", 32'(w_cnt), mcnt & 32'hF);
    chk("busy", 32'(Busy), 32'(mv || (Flush && rm0)));
  endtask

  task automatic cycle(input bit fl, input bit rd);
    bit e1, e2, hs;
    Flush   = fl;
    OpReady = rd;
    drive_fifo();
    @(negedge clk);
    check_all(e1, e2);
    hs = mv && rd;
    @(posedge clk);
    #1;
    if (hs) mcnt++;
    if (e2) begin
      ma = q[0]; mb = q[1]; mpad = 1'b0; mv = 1'b1;
      void'(q.pop_front());
      void'(q.pop_front());
    end else if (e1) begin
      ma = q[0]; mb = 32'h0; mpad = 1'b1; mv = 1'b1;
      void'(q.pop_front());
    end else if (hs) begin
      mv = 1'b0;
    end
    drive_fifo();
  endtask

  task automatic model_reset();
    mv = 1'b0; mpad = 1'b0; ma = 32'h0; mb = 32'h0; mcnt = 0;
  endtask

  initial begin
    bit e1, e2;
    rst = 1'b0;
    stale = 1'b0;
    Flush = 1'b0;
    OpReady = 1'b0;
    model_reset();
    q = '{32'd1, 32'd2, 32'd3, 32'd4};
    drive_fifo();

    // reset held with a full FIFO visible
    repeat (3) begin
      @(negedge clk);
      check_all(e1, e2);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // streaming two pairs
    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 1);
    chk("pc_after_pairs", 32'(PairCount), 32'd2);

    // back-pressure holds the pair
    q = '{32'd1, 32'd2, 32'd3, 32'd4};
    cycle(0, 0);
    repeat (3) cycle(0, 0);
    chk("held_a", OpA, 32'd1);
    chk("held_b", OpB, 32'd2);
    cycle(0, 1);
    chk("reload_a", OpA, 32'd3);
    chk("reload_b", OpB, 32'd4);
    cycle(0, 1);

    // odd trailing entry released only by flush
    q = '{32'd5, 32'd6, 32'd7};
    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 1);
    chk("waiting_7", 32'(q.size()), 32'd1);
    cycle(1, 1);
    chk("pad_a", OpA, 32'd7);
    chk("pad_b", OpB, 32'd0);
    chk("pad_flag", 32'(OpPad), 32'd1);
    cycle(0, 1);

    // Empty overrides stale ReadyM
    stale = 1'b1;
    repeat (3) cycle(0, 1);
    chk("stale_idle", 32'(OpValid), 32'd0);
    stale = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      while (q.size() < 4 && $urandom_range(0, 2) != 0)
        q.push_back($urandom);
      stale = ($urandom_range(0, 15) == 0);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    stale = 1'b0;
    cycle(1, 1);
    cycle(1, 1);
    cycle(1, 1);

    // async reset during HOLD
    q = '{32'd8, 32'd9, 32'd10, 32'd11};
    cycle(0, 0);
    chk("hold_before_rst", 32'(OpValid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(OpValid), 32'd0);
    chk("arst_count", 32'(PairCount), 32'd0);
    chk("arst_a", OpA, 32'd0);
    chk("arst_pop2", 32'(Pop2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(0, 1);
    cycle(0, 1);
    cycle(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
